// File: rtl/ctrl_seq_tab.sv
// ctrl_seq_tab: sequencer for the 4-bit ea state-code bus.
// Steps ea over [0, lim] up or down with a prescaled delay and valid/ack handshake.
module ctrl_seq_tab #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             modo,
  input  logic [3:0]       lim,
  input  logic [DIV_W-1:0] div,
  input  logic             pause,
  input  logic             ack,
  output logic [3:0]       ea,
  output logic             valido,
  output logic             ocupado,
  output logic             fim
);

  typedef enum logic [1:0] {
    OCIOSO,
    APRESENTA,
    CONTA,
    FIM
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [3:0]       ea_q;
  logic [3:0]       lim_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_q;
  logic             modo_q;
  logic             valido_q;
  logic             ocupado_q;
  logic             fim_q;

  logic             at_end_d;
  logic [3:0]       ea_step_d;
  logic             presc_zero_d;

  // End code is checked before stepping, so ea never leaves [0, lim_q].
  assign at_end_d     = modo_q ? (ea_q == 4'd0) : (ea_q == lim_q);
  assign ea_step_d    = modo_q ? (ea_q - 4'd1) : (ea_q + 4'd1);
  assign presc_zero_d = (presc_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OCIOSO;
      ea_q      <= 4'd0;
      lim_q     <= 4'd0;
      div_q     <= '0;
      presc_q   <= '0;
      modo_q    <= 1'b0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      fim_q <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (start) begin
            lim_q     <= lim;
            div_q     <= div;
            modo_q    <= modo;
            ea_q      <= modo ? lim : 4'd0;
            valido_q  <= 1'b1;
            ocupado_q <= 1'b1;
            state_q   <= APRESENTA;
          end
        end
        APRESENTA: begin
          if (ack) begin
            valido_q <= 1'b0;
            if (at_end_d) begin
              state_q <= FIM;
            end else begin
              presc_q <= div_q;
              state_q <= CONTA;
            end
          end
        end
        CONTA: begin
          if (!pause) begin
            if (!presc_zero_d) begin
              presc_q <= presc_q - PRESC_ONE;
            end else begin
              ea_q     <= ea_step_d;
              valido_q <= 1'b1;
              state_q  <= APRESENTA;
            end
          end
        end
        FIM: begin
          fim_q     <= 1'b1;
          ocupado_q <= 1'b0;
          state_q   <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign ea      = ea_q;
  assign valido  = valido_q;
  assign ocupado = ocupado_q;
  assign fim     = fim_q;

endmodule

// File: tb/tb_ctrl_seq_tab.sv
// tb_ctrl_seq_tab: scoreboard bench for ctrl_seq_tab.
// Driver queues expected codes/gaps/fim; monitor pops on valido rise or fim.
module tb_ctrl_seq_tab;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       modo;
  logic [3:0] lim;
  logic [7:0] div;
  logic       pause;
  logic       ack;
  logic [3:0] ea;
  logic       valido;
  logic       ocupado;
  logic       fim;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit is_fim;
    int code;
    int gap;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ctrl_seq_tab #(.DIV_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .modo    (modo),
    .lim     (lim),
    .div     (div),
    .pause   (pause),
    .ack     (ack),
    .ea      (ea),
    .valido  (valido),
    .ocupado (ocupado),
    .fim     (fim)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: samples on falling edge, compares against the scoreboard.
  initial begin : mon
    bit   pv;
    int   low;
    int   held;
    exp_t e;
    pv   = 1'b0;
    low  = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv  = 1'b0;
        low = 0;
      end else begin
        if (valido && !pv) begin
          if (exp_q.size() == 0) begin
            chk("extra_code", int'(ea), -1);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_code", 0, int'(e.is_fim));
            chk("code", int'(ea), e.code);
            if (e.gap >= 0) chk("gap", low, e.gap);
            chk("busy_with_code", int'(ocupado), 1);
          end
          held = int'(ea);
        end else if (valido) begin
          chk("hold_while_valid", int'(ea), held);
        end
        if (fim) begin
          if (exp_q.size() == 0) begin
            chk("extra_fim", int'(fim), 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_fim", 1, int'(e.is_fim));
            chk("fim_code", int'(ea), e.code);
            chk("fim_busy", int'(ocupado), 0);
            chk("fim_valid", int'(valido), 0);
          end
        end
        low = valido ? 0 : low + 1;
        pv  = valido;
      end
    end
  end

  // One sequence: pidx/plen add a pause before code pidx, abort_at resets mid-run.
  task automatic run_seq(input int l, input int d, input bit m,
                         input int adly, input bit noise,
                         input int pidx, input int plen, input int abort_at);
    exp_t e;
    int   last;
    int   c;
    last = (abort_at >= 0) ? abort_at : l;
    for (int i = 0; i <= last; i++) begin
      e.is_fim = 1'b0;
      e.code   = m ? (l - i) : i;
      e.gap    = (i == 0) ? -1 : (d + 1 + ((i == pidx) ? plen : 0));
      exp_q.push_back(e);
    end
    if (abort_at < 0) begin
      e.is_fim = 1'b1;
      e.code   = m ? 0 : l;
      e.gap    = -1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    lim   = l[3:0];
    div   = d[7:0];
    modo  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= last; i++) begin
      c = 0;
      while (!valido && c < 300) begin
        pause = (i == pidx) && (c < plen);
        ack   = noise;
        start = noise;
        if (noise) begin
          lim  = 4'($urandom);
          div  = 8'($urandom);
          modo = ~modo;
        end
        @(negedge clk);
        c++;
      end
      pause = 1'b0;
      ack   = 1'b0;
      start = 1'b0;
      if (!valido) begin
        chk("valid_timeout", int'(valido), 1);
        exp_q.delete();
        return;
      end
      repeat (adly) begin
        start = noise;
        @(negedge clk);
      end
      start = 1'b0;
      ack   = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ea", int'(ea), 0);
        chk("rst_valido", int'(valido), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_fim", int'(fim), 0);
        rst = 1'b0;
        chk("rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        return;
      end
      if (i == last && noise) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", int'(ocupado), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst   = 1'b1;
    start = 1'b0;
    modo  = 1'b0;
    lim   = 4'd0;
    div   = 8'd0;
    pause = 1'b0;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ea", int'(ea), 0);
    chk("reset_valido", int'(valido), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_fim", int'(fim), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in CONTA with ea=5.
    run_seq(9, 3, 1'b0, 0, 1'b0, -1, 0, 5);
    repeat (2) @(negedge clk);
    // Up 0..3, immediate ack.
    run_seq(3, 0, 1'b0, 0, 1'b0, -1, 0, -1);
    // Down 9..0, div=2, ack one cycle late.
    run_seq(9, 2, 1'b1, 1, 1'b0, -1, 0, -1);
    // Long ack stall plus 4-cycle pause before code 1.
    run_seq(2, 1, 1'b0, 10, 1'b0, 1, 4, -1);
    // Single-code ranges.
    run_seq(0, 0, 1'b0, 0, 1'b0, -1, 0, -1);
    run_seq(0, 3, 1'b1, 2, 1'b0, -1, 0, -1);
    // Full range up, must stop at 15.
    run_seq(15, 0, 1'b0, 0, 1'b0, -1, 0, -1);
    // Stray start/ack and config changes during the run.
    run_seq(5, 2, 1'b0, 2, 1'b1, -1, 0, -1);
    run_seq(4, 1, 1'b1, 1, 1'b1, 2, 3, -1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_tab.md
Name: ctrl_seq_tab

Overview:
- Sequencer for the 4-bit state-code bus `ea` that feeds the team's 7-segment-style output decoder.
- On `start`, steps `ea` through a programmable range, up or down, with a programmable inter-step delay.
- Each code is presented with a `valido` flag and held until the consumer acknowledges it.
- Owns the only state register for `ea`; the output decoder is downstream and purely combinational.

Parameters:
DIV_W, 8, width of the inter-step prescaler and of the `div` input.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  begin a sequence; sampled only in OCIOSO
modo  input  1  0 = count up 0→lim, 1 = count down lim→0; sampled with start
lim  input  4  last/first code of range (0..15); sampled with start
div  input  DIV_W  extra wait cycles between steps; sampled with start
pause  input  1  freezes prescaler/stepping while high
ack  input  1  consumer accepts current code; meaningful only while valido=1
ea  output  4  current state code to output decoder (registered)
valido  output  1  ea holds a new code awaiting ack (registered)
ocupado  output  1  sequence in progress (registered)
fim  output  1  one-cycle pulse after last code acknowledged (registered)

Behaviour:
- Reset (rst=1 at an edge): state=OCIOSO, ea=0, valido=0, ocupado=0, fim=0, prescaler=0, captured config=0. Reset overrides every other input, including mid-sequence.
- States: OCIOSO, APRESENTA, CONTA, FIM (2-bit encoding, free choice).
- OCIOSO:
  - With start=1: capture lim_r, div_r, modo_r. Load ea=0 if modo=0, else ea=lim. Set valido=1, ocupado=1, then go to APRESENTA.
  - Otherwise hold all outputs; ea keeps its last value.
- APRESENTA:
  - valido=1 and ea stable.
  - With ack=1: valido←0. If ea equals the end code (lim_r for up, 0 for down), go to FIM. Otherwise load prescaler←div_r and go to CONTA.
  - pause is ignored in this state.
- CONTA:
  - If pause=1, hold everything.
  - If pause=0 and prescaler≠0, decrement the prescaler.
  - If pause=0 and prescaler=0: ea←ea+1 (up) or ea−1 (down), valido←1, go to APRESENTA.
- FIM: fim=1 for exactly one cycle, ocupado←0, go to OCIOSO. start is ignored in FIM.
- Latency:
  - start at edge k gives valido=1 after edge k.
  - ack at edge k gives valido low for exactly div_r+1 cycles (without pause), then the next code.
  - The last ack at edge k gives fim=1 during cycle k+1 → k+2.
- Stepping never wraps: the end check runs before each step, so ea stays within [0, lim_r].
- lim=0: a single code 0 is presented, then fim.
- Input sampling:
  - start while not OCIOSO is ignored.
  - Changes to lim/div/modo after start have no effect.
  - ack while valido=0 is ignored.

Test Plan:
- Reset mid-sequence: rst during CONTA with ea=5 → next cycle ea=0, valido=0, ocupado=0, fim=0, state OCIOSO.
- Up count: lim=3, div=0, modo=0, ack tied high → ea presents 0,1,2,3. valido is high 1 cycle and low 1 cycle per code; fim pulses once after code 3; ocupado falls with fim.
- Down count with delay: lim=9, div=2, modo=1, ack one cycle after each valido → codes 9..0 in order, each valido gap exactly 3 cycles, single fim pulse, ea=0 at end.
- Handshake stall plus pause: hold ack low 10 cycles → ea and valido stay constant. Then ack, and pause for 4 cycles during CONTA (div=1) → gap extends from 2 to 6 cycles.
- Boundary config: lim=0 → one code (0), fim next after ack. lim=15, modo=0 → reaches 15 and ends, with no wrap to 0.
- Ignored inputs: start pulses during APRESENTA/CONTA/FIM, lim/div changed mid-run, ack while valido=0 → no effect on sequence or timing.
